// File: rtl/noise_lfsr_arbiter.sv
// rtl/noise_lfsr_arbiter.sv - shared Fibonacci LFSR noise source with round-robin requester arbitration
//
// Optional feature macro: NOISE_ARB_PRIO_EN
//   defined     : req[0] is strict high priority; requesters 1..NUM_REQ-1 round-robin
//   not defined : pure round-robin over all NUM_REQ requesters
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   req        in   level request, one bit per requester
//   steps_cfg  in   LFSR steps per word, latched at grant (0 treated as 1)
//   seed_load  in   load seed_in into the LFSR (honoured in IDLE only)
//   seed_in    in   seed value (zero is replaced by SEED)
//   done       out  one-hot 1-cycle pulse to the served requester
//   data       out  registered word, updated on DONE entry
//   data_valid out  high exactly in the DONE cycle
//   gnt_id     out  index of current/last grant
//   busy       out  high in RUN and DONE
//   seed_rej   out  1-cycle pulse: seed_load seen outside IDLE and ignored
//   lockup     out  sticky: a zero LFSR value was replaced by SEED
module noise_lfsr_arbiter #(
    parameter int                 NUM_REQ = 4,
    parameter int                 WIDTH   = 24,
    parameter logic [WIDTH-1:0]   TAPS    = 24'hE10000,
    parameter logic [WIDTH-1:0]   SEED    = 24'h000001
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [7:0]                 steps_cfg,
    input  logic                       seed_load,
    input  logic [WIDTH-1:0]           seed_in,
    output logic [NUM_REQ-1:0]         done,
    output logic [WIDTH-1:0]           data,
    output logic                       data_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic                       seed_rej,
    output logic                       lockup
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   last_gnt;
    logic [IDW-1:0]   winner;
    logic             any_req;
    logic             grant;
    logic             final_step;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_shift;
    logic [WIDTH-1:0] lfsr_adv;

    assign lfsr_shift = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    // An all-zero state would stick forever; recover to SEED instead.
    assign lfsr_adv   = (lfsr_shift == '0) ? SEED : lfsr_shift;

    // Round-robin search starting just after last_gnt. The loop runs from the
    // farthest candidate to the nearest so the nearest set request wins.
    always_comb begin
        int idx;
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
`ifdef NOISE_ARB_PRIO_EN
        // Ring covers only 1..NUM_REQ-1; last_gnt never holds 0 here.
        for (int i = NUM_REQ - 1; i >= 1; i--) begin
            idx = int'(last_gnt) + i;
            if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
            if (req[idx[IDW-1:0]]) begin
                winner  = idx[IDW-1:0];
                any_req = 1'b1;
            end
        end
        if (req[0]) begin
            winner  = '0;
            any_req = 1'b1;
        end
`else
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(last_gnt) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx[IDW-1:0]]) begin
                winner  = idx[IDW-1:0];
                any_req = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        final_step = 1'b0;
        busy       = 1'b0;
        data_valid = 1'b0;
        done       = '0;
        case (state)
            S_IDLE: begin
                // A seed load claims the cycle; arbitration waits.
                if (!seed_load && any_req) begin
                    grant     = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == 8'd1) begin
                    final_step = 1'b1;
                    state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                data_valid   = 1'b1;
                done[gnt_id] = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= SEED;
            cnt      <= '0;
            data     <= '0;
            gnt_id   <= '0;
            last_gnt <= IDW'(NUM_REQ - 1);
            seed_rej <= 1'b0;
            lockup   <= 1'b0;
        end else begin
            seed_rej <= seed_load && (state != S_IDLE);

            if (state == S_IDLE && seed_load) begin
                if (seed_in == '0) begin
                    lfsr   <= SEED;
                    lockup <= 1'b1;
                end else begin
                    lfsr <= seed_in;
                end
            end

            if (grant) begin
                gnt_id <= winner;
`ifdef NOISE_ARB_PRIO_EN
                if (winner != '0) last_gnt <= winner;
`else
                last_gnt <= winner;
`endif
                cnt <= (steps_cfg == 8'd0) ? 8'd1 : steps_cfg;
            end

            if (state == S_RUN) begin
                lfsr <= lfsr_adv;
                cnt  <= cnt - 8'd1;
                if (lfsr_shift == '0) lockup <= 1'b1;
                if (final_step) data <= lfsr_adv;
            end
        end
    end

endmodule

// File: tb/tb_noise_lfsr_arbiter.sv
// tb/tb_noise_lfsr_arbiter.sv - self-checking bench for noise_lfsr_arbiter
module tb_noise_lfsr_arbiter;

    localparam int          N    = 4;
    localparam logic [23:0] TAPS = 24'hE10000;
    localparam logic [23:0] SEED = 24'h000001;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  steps_cfg;
    logic        seed_load;
    logic [23:0] seed_in;
    logic [3:0]  done;
    logic [23:0] data;
    logic        data_valid;
    logic [1:0]  gnt_id;
    logic        busy;
    logic        seed_rej;
    logic        lockup;

    always #5 clk = ~clk;

    noise_lfsr_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (24),
        .TAPS    (TAPS),
        .SEED    (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .steps_cfg  (steps_cfg),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .done       (done),
        .data       (data),
        .data_valid (data_valid),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .seed_rej   (seed_rej),
        .lockup     (lockup)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int busy_cnt = 0;

    // Transaction-level model: a grant computes the whole word at once and
    // the model only counts down the cycles until it is delivered.
    bit          m_valid = 1'b0;
    logic [23:0] m_lfsr, m_word, m_data;
    int          m_left, m_gid, m_last;
    bit          m_lockup, m_rej;

    logic [23:0] obs_data[$];
    int          obs_gnt[$];
    logic [3:0]  obs_done[$];
    int          obs_cyc[$];

    function automatic logic [23:0] advance(logic [23:0] s, int n);
        for (int k = 0; k < n; k++) begin
            s = {s[22:0], ^(s & TAPS)};
            if (s == 24'd0) s = SEED;
        end
        return s;
    endfunction

    function automatic int pick(logic [3:0] r, int last);
        int c;
`ifdef NOISE_ARB_PRIO_EN
        if (r[0]) return 0;
        for (int k = 1; k < N; k++) begin
            c = ((last - 1 + k) % (N - 1)) + 1;
            if (r[c]) return c;
        end
`else
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (r[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic model_update();
        int w, s;
        if (reset) begin
            m_valid  = 1'b1;
            m_lfsr   = SEED;
            m_word   = SEED;
            m_data   = 24'd0;
            m_left   = 0;
            m_gid    = 0;
            m_last   = N - 1;
            m_lockup = 1'b0;
            m_rej    = 1'b0;
        end else if (m_valid) begin
            m_rej = seed_load && (m_left != 0);
            if (m_left != 0) begin
                m_left--;
                if (m_left == 1) m_data = m_word;
            end else if (seed_load) begin
                if (seed_in == 24'd0) begin
                    m_lfsr   = SEED;
                    m_lockup = 1'b1;
                end else begin
                    m_lfsr = seed_in;
                end
            end else if (req != 4'd0) begin
                w     = pick(req, m_last);
                s     = (steps_cfg == 8'd0) ? 1 : int'(steps_cfg);
                m_gid = w;
`ifdef NOISE_ARB_PRIO_EN
                if (w != 0) m_last = w;
`else
                m_last = w;
`endif
                m_word = advance(m_lfsr, s);
                m_lfsr = m_word;
                m_left = s + 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic compare();
        chk("busy",       32'(busy),       32'(m_left != 0));
        chk("data_valid", 32'(data_valid), 32'(m_left == 1));
        chk("done",       32'(done),       (m_left == 1) ? (32'd1 << m_gid) : 32'd0);
        chk("data",       32'(data),       32'(m_data));
        chk("gnt_id",     32'(gnt_id),     32'(m_gid));
        chk("seed_rej",   32'(seed_rej),   32'(m_rej));
        chk("lockup",     32'(lockup),     32'(m_lockup));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_update();
        @(negedge clk);
        cyc++;
        if (m_valid) compare();
        if (busy === 1'b1) busy_cnt++;
        if (data_valid === 1'b1) begin
            obs_data.push_back(data);
            obs_gnt.push_back(int'(gnt_id));
            obs_done.push_back(done);
            obs_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_gnt.delete();
        obs_done.delete();
        obs_cyc.delete();
    endtask

    task automatic expect_word(input string name, input int i, input logic [23:0] d,
                               input int g, input logic [3:0] dn);
        if (obs_data.size() > i) begin
            chk({name, "_data"}, 32'(obs_data[i]), 32'(d));
            chk({name, "_gnt"},  32'(obs_gnt[i]),  32'(g));
            chk({name, "_done"}, 32'(obs_done[i]), 32'(dn));
        end else begin
            chk({name, "_present"}, 32'(obs_data.size()), 32'(i + 1));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    initial begin
        int exp_g[5];
        reset     = 1'b1;
        req       = 4'd0;
        steps_cfg = 8'd0;
        seed_load = 1'b0;
        seed_in   = 24'd0;
        do_reset();

        // Reset state
        chk("rst_data",   32'(data),   32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_gnt",    32'(gnt_id), 32'd0);
        chk("rst_lockup", 32'(lockup), 32'd0);

        // Single word from SEED, four steps
        clear_obs();
        busy_cnt  = 0;
        req       = 4'b0001;
        steps_cfg = 8'd4;
        cycle();
        req = 4'b0000;
        repeat (7) cycle();
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd5);
        expect_word("t1", 0, 24'h000010, 0, 4'b0001);

        // steps_cfg=0 behaves as one step
        clear_obs();
        seed_load = 1'b1;
        seed_in   = 24'h000001;
        cycle();
        seed_load = 1'b0;
        req       = 4'b0100;
        steps_cfg = 8'd0;
        cycle();
        req = 4'b0000;
        repeat (3) cycle();
        expect_word("t2", 0, 24'h000002, 2, 4'b0100);

        // All requesters held, one word every 3 cycles
        do_reset();
        clear_obs();
        req       = 4'b1111;
        steps_cfg = 8'd1;
        repeat (15) cycle();
        req = 4'b0000;
        repeat (3) cycle();
`ifdef NOISE_ARB_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 3, 0};
`endif
        chk("t3_count", 32'(obs_gnt.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (obs_gnt.size() > i) chk("t3_order", 32'(obs_gnt[i]), 32'(exp_g[i]));
            if (obs_cyc.size() > i + 1) chk("t3_spacing", 32'(obs_cyc[i+1] - obs_cyc[i]), 32'd3);
        end

        // Zero seed recovery and rejected seed load
        do_reset();
        clear_obs();
        chk("t4_lockup0", 32'(lockup), 32'd0);
        seed_load = 1'b1;
        seed_in   = 24'd0;
        cycle();
        seed_load = 1'b0;
        chk("t4_lockup1", 32'(lockup), 32'd1);
        req       = 4'b0001;
        steps_cfg = 8'd3;
        cycle();
        req       = 4'b0000;
        seed_load = 1'b1;
        seed_in   = 24'hABCDEF;
        cycle();
        seed_load = 1'b0;
        chk("t4_seed_rej", 32'(seed_rej), 32'd1);
        repeat (4) cycle();
        expect_word("t4", 0, 24'h000008, 0, 4'b0001);
        chk("t4_lockup_sticky", 32'(lockup), 32'd1);

        // Reset in the middle of RUN
        req       = 4'b0001;
        steps_cfg = 8'd10;
        cycle();
        req = 4'b0000;
        repeat (3) cycle();
        reset = 1'b1;
        clear_obs();
        cycle();
        reset = 1'b0;
        chk("t5_busy",       32'(busy),       32'd0);
        chk("t5_done",       32'(done),       32'd0);
        chk("t5_data",       32'(data),       32'd0);
        chk("t5_data_valid", 32'(data_valid), 32'd0);
        repeat (12) cycle();
        chk("t5_no_stray", 32'(obs_data.size()), 32'd0);

`ifdef NOISE_ARB_PRIO_EN
        // Strict priority for req[0], then round-robin among 1 and 3
        do_reset();
        clear_obs();
        req       = 4'b1011;
        steps_cfg = 8'd1;
        repeat (9) cycle();
        for (int i = 0; i < 3; i++) expect_word("t6_prio", i, obs_data.size() > i ? obs_data[i] : 24'd0, 0, 4'b0001);
        req = 4'b0000;
        repeat (4) cycle();
        clear_obs();
        req = 4'b1010;
        repeat (12) cycle();
        req = 4'b0000;
        repeat (3) cycle();
        exp_g[0] = 1; exp_g[1] = 3; exp_g[2] = 1; exp_g[3] = 3;
        for (int i = 0; i < 4; i++) begin
            if (obs_gnt.size() > i) chk("t6_rr", 32'(obs_gnt[i]), 32'(exp_g[i]));
            else chk("t6_rr_present", 32'(obs_gnt.size()), 32'(i + 1));
        end
`endif

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            steps_cfg = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40))
                                                     : 8'($urandom_range(0, 5));
            seed_load = ($urandom_range(0, 19) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
            reset     = ($urandom_range(0, 399) == 0);
            cycle();
        end
        reset     = 1'b0;
        req       = 4'd0;
        seed_load = 1'b0;
        repeat (50) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
